// File: rtl/micro_sequencer_if.sv
// micro_sequencer_if: handshake/bus bundle between the control-unit datapath and the micro-sequencer
//   master: drives START, BR, NXTADD, ZFLAG, OPCODE, MEMBUSY; observes ROMADDR, STALL, HALTED, ILLEGAL, INSTCOUNT
//   slave : the sequencer side of the same signals
interface micro_sequencer_if #(
  parameter int ADDR_W = 5,
  parameter int OPC_W  = 8
);
  logic              START;
  logic              BR;
  logic [ADDR_W-1:0] NXTADD;
  logic              ZFLAG;
  logic [OPC_W-1:0]  OPCODE;
  logic              MEMBUSY;
  logic [ADDR_W-1:0] ROMADDR;
  logic              STALL;
  logic              HALTED;
  logic              ILLEGAL;
  logic [15:0]       INSTCOUNT;
  modport master (
    output START, BR, NXTADD, ZFLAG, OPCODE, MEMBUSY,
    input  ROMADDR, STALL, HALTED, ILLEGAL, INSTCOUNT
  );
  modport slave (
    input  START, BR, NXTADD, ZFLAG, OPCODE, MEMBUSY,
    output ROMADDR, STALL, HALTED, ILLEGAL, INSTCOUNT
  );
endinterface

// File: rtl/micro_sequencer.sv
// micro_sequencer: picks the next microcode ROM address each rising edge (start/halt, dispatch, branch, stall)
//   clk : system clock, rising edge only
//   rst : asynchronous active-high reset
//   bus : micro_sequencer_if.slave -- START/BR/NXTADD/ZFLAG/OPCODE/MEMBUSY in,
//         ROMADDR/STALL/HALTED/ILLEGAL/INSTCOUNT out (all outputs registered)
module micro_sequencer #(
  parameter int ADDR_W = 5,
  parameter int OPC_W  = 8,
  parameter logic [ADDR_W-1:0] FETCH_ADDR    = 5'h00,
  parameter logic [ADDR_W-1:0] IDLE_ADDR     = 5'h1D,
  parameter logic [ADDR_W-1:0] HALT_CODE     = 5'h1E,
  parameter logic [ADDR_W-1:0] DISPATCH_CODE = 5'h1F
) (
  input logic clk,
  input logic rst,
  micro_sequencer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic stall_q, stall_d, halted_q, halted_d, ill_q, ill_d;
  logic [15:0] cnt_q, cnt_d;
  logic [ADDR_W:0] inc;
  logic bad_opc, to_halt;
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    stall_d  = 1'b0;
    halted_d = halted_q;
    ill_d    = ill_q;
    cnt_d    = cnt_q;
    to_halt  = 1'b0;
    // one extra bit so stepping past the top of the address space is caught instead of wrapping
    inc      = {1'b0, addr_q} + (ADDR_W+1)'(1);
    bad_opc  = (bus.OPCODE >> ADDR_W) != '0 || bus.OPCODE[ADDR_W-1:0] >= IDLE_ADDR;
    if (state_q != RUN) begin
      addr_d   = IDLE_ADDR;
      halted_d = state_q == HALT;
      if (bus.START) begin
        state_d  = RUN;
        addr_d   = FETCH_ADDR;
        halted_d = 1'b0;
        ill_d    = 1'b0;
        cnt_d    = '0;
      end
    end else if (bus.MEMBUSY) begin
      stall_d = 1'b1;
    end else if (!bus.BR && bus.NXTADD == HALT_CODE) begin
      to_halt = 1'b1;
    end else if (!bus.BR && bus.NXTADD == DISPATCH_CODE) begin
      to_halt = bad_opc;
      ill_d   = ill_q | bad_opc;
      addr_d  = bad_opc ? addr_q : bus.OPCODE[ADDR_W-1:0];
      cnt_d   = bad_opc ? cnt_q : cnt_q + 16'd1;
    end else if (!bus.BR || bus.ZFLAG) begin
      addr_d = bus.NXTADD;
    end else begin
      to_halt = inc >= {1'b0, IDLE_ADDR};
      ill_d   = ill_q | to_halt;
      addr_d  = inc[ADDR_W-1:0];
    end
    if (to_halt) begin
      state_d  = HALT;
      addr_d   = IDLE_ADDR;
      halted_d = 1'b1;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      addr_q   <= IDLE_ADDR;
      stall_q  <= 1'b0;
      halted_q <= 1'b0;
      ill_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      stall_q  <= stall_d;
      halted_q <= halted_d;
      ill_q    <= ill_d;
      cnt_q    <= cnt_d;
    end
  end
  assign bus.ROMADDR   = addr_q;
  assign bus.STALL     = stall_q;
  assign bus.HALTED    = halted_q;
  assign bus.ILLEGAL   = ill_q;
  assign bus.INSTCOUNT = cnt_q;
endmodule

// File: tb/tb_micro_sequencer.sv
// tb_micro_sequencer: directed plus randomized checks of micro_sequencer against a behavioural model
module tb_micro_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_cmp = 0;
  int n_bad = 0;
  micro_sequencer_if sif();
  micro_sequencer dut (.clk(clk), .rst(rst), .bus(sif.slave));
  always #5 clk = ~clk;
  int m_st;
  logic [4:0] m_addr;
  logic m_stall, m_halt, m_ill;
  logic [15:0] m_cnt;
  task automatic m_reset();
    m_st = 0; m_addr = 5'h1D; m_stall = 0; m_halt = 0; m_ill = 0; m_cnt = 0;
  endtask
  task automatic m_halt_to(input bit ill);
    m_st = 2; m_addr = 5'h1D; m_halt = 1; m_ill = m_ill | ill;
  endtask
  task automatic model_step();
    m_stall = 0;
    if (m_st != 1) begin
      m_addr = 5'h1D;
      if (sif.START) begin
        m_st = 1; m_addr = 5'h00; m_cnt = 0; m_halt = 0; m_ill = 0;
      end
    end else if (sif.MEMBUSY) m_stall = 1;
    else if (!sif.BR && sif.NXTADD == 5'h1E) m_halt_to(0);
    else if (!sif.BR && sif.NXTADD == 5'h1F) begin
      if (int'(sif.OPCODE) >= 29) m_halt_to(1);
      else begin
        m_addr = sif.OPCODE[4:0];
        m_cnt = m_cnt + 16'd1;
      end
    end else if (!sif.BR || sif.ZFLAG) m_addr = sif.NXTADD;
    else if (int'(m_addr) + 1 >= 29) m_halt_to(1);
    else m_addr = m_addr + 5'd1;
  endtask
  task automatic chk(input string tag);
    n_cmp++;
    assert (sif.ROMADDR === m_addr) else begin n_bad++; $error("FAIL %s ROMADDR got %h exp %h", tag, sif.ROMADDR, m_addr); end
    n_cmp++;
    assert (sif.STALL === m_stall) else begin n_bad++; $error("FAIL %s STALL got %b exp %b", tag, sif.STALL, m_stall); end
    n_cmp++;
    assert (sif.HALTED === m_halt) else begin n_bad++; $error("FAIL %s HALTED got %b exp %b", tag, sif.HALTED, m_halt); end
    n_cmp++;
    assert (sif.ILLEGAL === m_ill) else begin n_bad++; $error("FAIL %s ILLEGAL got %b exp %b", tag, sif.ILLEGAL, m_ill); end
    n_cmp++;
    assert (sif.INSTCOUNT === m_cnt) else begin n_bad++; $error("FAIL %s INSTCOUNT got %h exp %h", tag, sif.INSTCOUNT, m_cnt); end
  endtask
  task automatic want(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    assert (got === exp) else begin n_bad++; $error("FAIL %s got %h exp %h", tag, got, exp); end
  endtask
  task automatic drive(input bit st, input bit br, input logic [4:0] nxt, input bit z, input logic [7:0] opc, input bit busy);
    sif.START = st; sif.BR = br; sif.NXTADD = nxt; sif.ZFLAG = z; sif.OPCODE = opc; sif.MEMBUSY = busy;
  endtask
  task automatic step(input string tag);
    @(posedge clk);
    model_step();
    #1;
    chk(tag);
  endtask
  initial begin
    drive(0, 0, 5'h00, 0, 8'h00, 0);
    m_reset();
    repeat (2) @(posedge clk);
    #4 rst = 1'b0;
    #1 chk("reset");
    want("reset_addr", 16'(sif.ROMADDR), 16'h1D);
    drive(0, 1, 5'h03, 1, 8'h02, 1);
    step("idle_ignores");
    drive(1, 0, 5'h01, 0, 8'h0A, 0);
    step("start");
    want("start_addr", 16'(sif.ROMADDR), 16'h00);
    drive(0, 0, 5'h01, 0, 8'h0A, 0);
    step("seq_01");
    drive(0, 0, 5'h1F, 0, 8'h0A, 0);
    step("dispatch_0a");
    want("dispatch_addr", 16'(sif.ROMADDR), 16'h0A);
    want("dispatch_cnt", sif.INSTCOUNT, 16'h0001);
    drive(1, 1, 5'h14, 1, 8'h00, 0);
    step("br_taken");
    want("br_taken_addr", 16'(sif.ROMADDR), 16'h14);
    drive(0, 0, 5'h0A, 0, 8'h00, 0);
    step("back_0a");
    drive(0, 1, 5'h14, 0, 8'h00, 0);
    step("br_incr");
    want("br_incr_addr", 16'(sif.ROMADDR), 16'h0B);
    drive(0, 0, 5'h05, 0, 8'h03, 0);
    step("to_05");
    drive(0, 0, 5'h1F, 0, 8'h03, 1);
    for (int i = 0; i < 3; i++) step("busy_hold");
    want("busy_stall", 16'(sif.STALL), 16'h1);
    sif.MEMBUSY = 0;
    step("busy_release");
    want("busy_cnt_once", sif.INSTCOUNT, 16'h0002);
    drive(0, 0, 5'h1F, 0, 8'h25, 0);
    step("opc_25_illegal");
    want("opc_25_ill", 16'({sif.ILLEGAL, sif.HALTED}), 16'h3);
    drive(1, 0, 5'h00, 0, 8'h00, 0);
    step("restart_1");
    want("restart_ill_clear", 16'(sif.ILLEGAL), 16'h0);
    drive(0, 0, 5'h1F, 0, 8'h1E, 0);
    step("opc_1e_illegal");
    drive(1, 0, 5'h00, 0, 8'h00, 0);
    step("restart_2");
    drive(0, 0, 5'h1C, 0, 8'h00, 0);
    step("to_1c");
    drive(0, 1, 5'h02, 0, 8'h00, 0);
    step("incr_overflow");
    want("incr_overflow_addr", 16'(sif.ROMADDR), 16'h1D);
    drive(1, 0, 5'h00, 0, 8'h00, 0);
    step("restart_3");
    drive(0, 0, 5'h1E, 0, 8'h00, 0);
    step("halt_word");
    for (int i = 0; i < 4; i++) begin
      drive(0, 1'($urandom), 5'($urandom), 1'($urandom), 8'($urandom), 1'($urandom));
      step("halt_hold");
    end
    drive(1, 0, 5'h07, 0, 8'h00, 0);
    step("restart_4");
    sif.START = 0;
    step("to_07");
    #3 rst = 1'b1;
    m_reset();
    #1 chk("async_reset");
    #2 rst = 1'b0;
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 15) == 0, 1'($urandom), 5'($urandom),
            1'($urandom), $urandom_range(0, 3) == 0 ? 8'($urandom) : 8'($urandom_range(0, 31)),
            $urandom_range(0, 3) == 0);
      step("random");
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/micro_sequencer.md
Name: micro_sequencer

Overview:
- Microprogram sequencer for the control unit. It drives the microcode ROM address each cycle.
- The ROM word is latched on the falling clock edge by the control-signal decoder, which returns BR and NXTADD.
- On the next rising edge the sequencer uses BR, NXTADD, the ALU zero flag, the IR opcode and the memory-busy handshake to pick the next micro-address.
- It also handles start/halt, opcode dispatch, stalls, illegal-flow detection and instruction counting.

Parameters:
ADDR_W, 5, micro-address width (matches NXTADD width)
OPC_W, 8, IR opcode width
FETCH_ADDR, 5'h00, first micro-address of the fetch routine
IDLE_ADDR, 5'h1D, micro-address of the self-looping NOP word, driven while idle or halted
HALT_CODE, 5'h1E, NXTADD value meaning halt (with BR=0)
DISPATCH_CODE, 5'h1F, NXTADD value meaning dispatch on opcode (with BR=0)

Ports:
clk  in  1  system clock; sequencer state changes on the rising edge only
rst  in  1  reset; asynchronous, active-high
START  in  1  level sampled at posedge; starts or restarts execution from IDLE/HALT
BR  in  1  branch flag from the decoded microword
NXTADD  in  ADDR_W  next-address field from the decoded microword
ZFLAG  in  1  ALU zero flag
OPCODE  in  OPC_W  opcode field of IR
MEMBUSY  in  1  memory not ready; microword must repeat
ROMADDR  out  ADDR_W  micro-address to the ROM (registered)
STALL  out  1  high while the current microword is a stall repeat; the datapath gates PCINC/R2INC/writes with it
HALTED  out  1  high in HALT
ILLEGAL  out  1  sticky; set on an illegal dispatch or increment
INSTCOUNT  out  16  number of dispatches since reset or START

Behaviour:
- Reset (async, immediate, mid-operation included): state=IDLE, ROMADDR=IDLE_ADDR, STALL=0, HALTED=0, ILLEGAL=0, INSTCOUNT=0.
- State machine, three states: IDLE, RUN, HALT.
- IDLE: ROMADDR=IDLE_ADDR. START=1 -> RUN with ROMADDR=FETCH_ADDR, INSTCOUNT=0. BR, NXTADD and MEMBUSY are ignored.
- RUN, evaluated each posedge in priority order:
  1. MEMBUSY=1: hold ROMADDR and set STALL=1 for the next cycle. STALL is registered, so STALL=1 means the word now latched is a repeat.
  2. BR=0 and NXTADD=HALT_CODE: -> HALT, ROMADDR=IDLE_ADDR, HALTED=1.
  3. BR=0 and NXTADD=DISPATCH_CODE:
     - If OPCODE[OPC_W-1:ADDR_W]!=0, or OPCODE[ADDR_W-1:0] is greater than or equal to IDLE_ADDR: set ILLEGAL=1 and go to HALT.
     - Otherwise ROMADDR=OPCODE[ADDR_W-1:0] and INSTCOUNT+1 (wraps 16'hFFFF->0).
  4. BR=0, any other NXTADD: ROMADDR=NXTADD.
  5. BR=1, ZFLAG=1: ROMADDR=NXTADD.
  6. BR=1, ZFLAG=0: ROMADDR=ROMADDR+1. If the result is greater than or equal to IDLE_ADDR (no wrap), set ILLEGAL=1 and go to HALT.
  - STALL=0 whenever MEMBUSY=0.
  - A BR=1 word whose NXTADD is a reserved code is a plain jump to that address.
- HALT:
  - ROMADDR=IDLE_ADDR and HALTED=1.
  - START=1 -> RUN with ROMADDR=FETCH_ADDR, HALTED=0, ILLEGAL=0, INSTCOUNT=0.
  - START during RUN is ignored.
- Timing:
  - One microword per clock. Posedge: ROMADDR updates. Negedge: the decoder latches ROM[ROMADDR]. Next posedge: the sequencer consumes BR/NXTADD.
  - After START, the first consumed word is ROM[FETCH_ADDR].
  - Latency from START sampled to ROMADDR=FETCH_ADDR: 1 posedge.
- Simultaneous events:
  - rst dominates all.
  - MEMBUSY beats halt, dispatch and branch: a stalled halt/dispatch word takes effect on the first non-busy edge, and INSTCOUNT increments exactly once.
  - ZFLAG is sampled only at that edge.

Test Plan:
- rst asserted mid-RUN (ROMADDR=5'h07) between edges -> ROMADDR=5'h1D, all flags 0, INSTCOUNT=0, no clock needed.
- START pulse; words 00:{BR0,NXT=01}, 01:{BR0,NXT=1F}, OPCODE=8'h0A -> ROMADDR sequence 1D,00,01,0A; INSTCOUNT=1.
- At 0A, BR=1, NXT=14: ZFLAG=1 -> 14; repeat with ZFLAG=0 -> 0B.
- MEMBUSY high for 3 edges at ROMADDR=05 with NXT=1F -> ROMADDR held at 05, STALL=1 for 3 cycles, then dispatch, INSTCOUNT+1 exactly once.
- Dispatch with OPCODE=8'h25, and separately 8'h1E -> ILLEGAL=1, HALTED=1, ROMADDR=1D. START -> ILLEGAL=0, ROMADDR=00.
- BR=1, ZFLAG=0 at ROMADDR=1C -> ILLEGAL=1, HALT. NXT=1E word -> HALTED=1, ROMADDR stays 1D until START.
